// File: rtl/gate_bist_if.sv
// Gate BIST bus: run control, DUT drive/response and result reporting.
//
// Run handshake: the host raises start; the BIST accepts it on a rising
// clock edge only while idle (busy=0), after which busy is 1 for the run.
// A start seen while busy is ignored. done rises with busy falling. done,
// pass, err_count and fail_vec are then held until the next start is
// accepted. pass is only meaningful while done is 1.
interface gate_bist_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_vec;
    logic [1:0]      dbg_state;

    // Host / gate-under-test side
    modport master (
        output start,
        output dut_out,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec,
        input  dbg_state
    );

    // BIST sequencer side
    modport slave (
        input  start,
        input  dut_out,
        output dut_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec,
        output dbg_state
    );
endinterface

// File: rtl/gate_bist.sv
// gate_bist: walks every input vector of a small combinational gate in
// ascending order, holds each for SETTLE cycles, samples the response and
// compares it with a golden gate function (OP: 0 AND, 1 OR, 2 XOR, 3 NAND).
// Optional macro BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
// All outputs are registered; dut_out only feeds next-state logic.
module gate_bist #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2,
    parameter int OP     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    gate_bist_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fail_q, fail_d;

    logic mismatch;
    logic run_end;

    function automatic logic golden(input logic [N_IN-1:0] v);
        case (OP)
            0:       return &v;
            1:       return |v;
            2:       return ^v;
            default: return ~&v;
        endcase
    endfunction

    // Response check against the golden function for the vector on dut_in
    assign mismatch = (bus.dut_out != golden(vec_q));

    // Run terminates on the last vector, or on the first mismatch when enabled
`ifdef BIST_STOP_ON_FAIL_EN
    assign run_end = (vec_q == LAST_VEC) || mismatch;
`else
    assign run_end = (vec_q == LAST_VEC);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_CHECK;
            S_CHECK: state_d = run_end ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        err_d  = err_q;
        fail_d = fail_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    vec_d  = '0;
                    cnt_d  = CNT_LOAD;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    err_d  = '0;
                    fail_d = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + (N_IN + 1)'(1);
                    if (err_q == '0) fail_d = vec_q;
                end
                if (run_end) begin
                    // dut_in keeps the final (or failing) vector
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_d == '0);
                end else begin
                    vec_d = vec_q + N_IN'(1);
                    cnt_d = CNT_LOAD;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            fail_q <= '0;
        end else begin
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            err_q  <= err_d;
            fail_q <= fail_d;
        end
    end

    assign bus.dut_in    = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: good, stuck-at-0 and stuck-at-1 AND gates
// on an AND-golden instance, plus an AND gate on an XOR-golden instance.
module tb_gate_bist;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_bist_if #(.N_IN(3)) bus_and ();
    gate_bist_if #(.N_IN(3)) bus_xor ();

    logic       start      = 1'b0;
    logic       sel_xor    = 1'b0;
    logic [1:0] fault_mode = 2'd0;   // 0 good AND, 1 stuck-at-0, 2 stuck-at-1

    assign bus_and.start   = start & ~sel_xor;
    assign bus_xor.start   = start & sel_xor;
    assign bus_and.dut_out = (fault_mode == 2'd0) ? (&bus_and.dut_in) :
                             (fault_mode == 2'd1) ? 1'b0 : 1'b1;
    assign bus_xor.dut_out = &bus_xor.dut_in;

    gate_bist #(.N_IN(3), .SETTLE(2), .OP(0)) u_and (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_and)
    );

    gate_bist #(.N_IN(3), .SETTLE(2), .OP(2)) u_xor (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_xor)
    );

    // observed outputs of the selected instance
    logic       o_busy, o_done, o_pass;
    logic [2:0] o_dut_in, o_fail;
    logic [3:0] o_err;
    logic [1:0] o_state;
    assign o_busy   = sel_xor ? bus_xor.busy      : bus_and.busy;
    assign o_done   = sel_xor ? bus_xor.done      : bus_and.done;
    assign o_pass   = sel_xor ? bus_xor.pass      : bus_and.pass;
    assign o_dut_in = sel_xor ? bus_xor.dut_in    : bus_and.dut_in;
    assign o_fail   = sel_xor ? bus_xor.fail_vec  : bus_and.fail_vec;
    assign o_err    = sel_xor ? bus_xor.err_count : bus_and.err_count;
    assign o_state  = sel_xor ? bus_xor.dbg_state : bus_and.dbg_state;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(o_busy),   32'd0);
        check({tag, "_done"},   32'(o_done),   32'd0);
        check({tag, "_pass"},   32'(o_pass),   32'd0);
        check({tag, "_dut_in"}, 32'(o_dut_in), 32'd0);
        check({tag, "_err"},    32'(o_err),    32'd0);
        check({tag, "_fail"},   32'(o_fail),   32'd0);
        check({tag, "_state"},  32'(o_state),  32'd0);
    endtask

    // ---------------- driver ----------------
    // Pulses start, checks the acceptance-edge state, then counts edges
    // until done. poke >= 0 re-pulses start at that cycle of the run.
    task automatic run(input int poke, input bit trace, output int lat);
        logic [2:0] exp_v;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("acc_busy", 32'(o_busy), 32'd1);
        check("acc_done", 32'(o_done), 32'd0);
        check("acc_pass", 32'(o_pass), 32'd0);
        check("acc_err",  32'(o_err),  32'd0);
        check("acc_fail", 32'(o_fail), 32'd0);
        check("acc_vec",  32'(o_dut_in), 32'd0);
        lat = 0;
        while (!o_done && lat < 100) begin
            if (trace && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                check("step_dut_in", 32'(o_dut_in), 32'(exp_v));
            end
            start = (lat == poke);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    int lat;

    initial begin
        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: good AND gate, each vector held 3 cycles
        fault_mode = 2'd0;
        for (int n = 0; n < 24; n++) exp_q.push_back(3'(n / 3));
        run(-1, 1'b1, lat);
        check("t1_lat",  32'(lat),      32'd24);
        check("t1_pass", 32'(o_pass),   32'd1);
        check("t1_err",  32'(o_err),    32'd0);
        check("t1_fail", 32'(o_fail),   32'd0);
        check("t1_busy", 32'(o_busy),   32'd0);
        check("t1_last", 32'(o_dut_in), 32'd7);
        repeat (3) @(posedge clk);
        #1;
        check("t1_hold_done", 32'(o_done), 32'd1);
        check("t1_hold_pass", 32'(o_pass), 32'd1);

        // 2: stuck-at-0, only vector 7 mismatches
        fault_mode = 2'd1;
        run(-1, 1'b0, lat);
        check("t2_lat",  32'(lat),    32'd24);
        check("t2_pass", 32'(o_pass), 32'd0);
        check("t2_err",  32'(o_err),  32'd1);
        check("t2_fail", 32'(o_fail), 32'd7);

        // 3: stuck-at-1, vectors 0..6 mismatch
        fault_mode = 2'd2;
        run(-1, 1'b0, lat);
`ifdef BIST_STOP_ON_FAIL_EN
        check("t3_lat",  32'(lat),      32'd3);
        check("t3_err",  32'(o_err),    32'd1);
        check("t3_vec",  32'(o_dut_in), 32'd0);
`else
        check("t3_lat",  32'(lat),      32'd24);
        check("t3_err",  32'(o_err),    32'd7);
        check("t3_vec",  32'(o_dut_in), 32'd7);
`endif
        check("t3_fail", 32'(o_fail), 32'd0);
        check("t3_pass", 32'(o_pass), 32'd0);

        // 6: back-to-back, good run after a failing one
        fault_mode = 2'd0;
        run(-1, 1'b0, lat);
        check("t6_lat",  32'(lat),    32'd24);
        check("t6_pass", 32'(o_pass), 32'd1);
        check("t6_err",  32'(o_err),  32'd0);

        // 5: reset mid-run (stuck-at-1 so results are non-zero by then)
        fault_mode = 2'd2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        fault_mode = 2'd0;
        run(5, 1'b0, lat);
        check("t5_lat",  32'(lat),    32'd24);
        check("t5_pass", 32'(o_pass), 32'd1);
        check("t5_err",  32'(o_err),  32'd0);
        check("t5_fail", 32'(o_fail), 32'd0);

        // 4: XOR golden against an AND gate: mismatches at 1, 2, 4
        sel_xor = 1'b1;
        run(-1, 1'b0, lat);
`ifdef BIST_STOP_ON_FAIL_EN
        check("t4_lat",  32'(lat),      32'd6);
        check("t4_err",  32'(o_err),    32'd1);
        check("t4_vec",  32'(o_dut_in), 32'd1);
`else
        check("t4_lat",  32'(lat),      32'd24);
        check("t4_err",  32'(o_err),    32'd3);
        check("t4_vec",  32'(o_dut_in), 32'd7);
`endif
        check("t4_fail", 32'(o_fail), 32'd1);
        check("t4_pass", 32'(o_pass), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Built-in self-test sequencer for a small combinational gate DUT, such as the 3-input AND.
- It drives every input vector into the DUT in ascending order and waits a programmable settle time before sampling the DUT output.
- It compares the sample against a golden model of the selected gate function and reports pass/fail, the error count and the first failing vector.
- It is the hardware stimulus and checker side of the gate interface: it replaces the simulation-only bench so the check can run on silicon or FPGA.

Parameters:
- N_IN, 3, DUT input width; 2^N_IN vectors are applied.
- SETTLE, 2, cycles each vector is held before sampling; legal range is 1 or greater.
- OP, 0, golden function over all N_IN bits: 0 = AND, 1 = OR, 2 = XOR (odd parity), 3 = NAND.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE only.
- dut_in  out  N_IN  vector driven to the DUT inputs.
- dut_out  in  1  DUT response.
- busy  out  1  run in progress.
- done  out  1  run finished; sticky until the next accepted start.
- pass  out  1  valid when done is high; 1 = no mismatches.
- err_count  out  N_IN+1  number of mismatching vectors.
- fail_vec  out  N_IN  first mismatching vector; 0 if there was none.

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE.
  - dut_in, busy, done, pass, err_count and fail_vec are all 0.
  - Reset mid-run aborts immediately with no partial results kept.
- State IDLE:
  - start=1 at an edge: vec=0, dut_in=0, busy=1, done=0, pass=0, err_count=0, fail_vec=0, settle counter=SETTLE-1; go to WAIT.
- State WAIT:
  - dut_in is held stable.
  - Counter decrements each cycle; at the cycle where it is 0, go to CHECK.
  - Each vector therefore sees SETTLE cycles in WAIT.
- State CHECK (1 cycle):
  - Compare dut_out against expected(vec, OP).
  - On mismatch: err_count += 1. If err_count was 0, fail_vec=vec.
  - If vec != 2^N_IN-1: vec += 1, dut_in updates at the same edge, counter=SETTLE-1, go to WAIT.
  - If vec == 2^N_IN-1: busy=0, done=1, pass = (no mismatch in the whole run, including this one), go to IDLE. dut_in holds the last vector.
- Latency:
  - done rises exactly 2^N_IN*(SETTLE+1) cycles after the edge that accepted start.
  - Default parameters give 24 cycles.
- Width rules:
  - err_count has N_IN+1 bits, so it holds 2^N_IN without overflow; no saturation logic is needed.
  - The vec counter must not wrap; termination is by the last-vector compare.
- Handshake and boundary cases:
  - start while busy is ignored.
  - start held high after done begins a new run on the next IDLE edge.
  - done and pass stay stable in IDLE until a start is accepted.
- Output timing: all outputs are registered; no output depends combinationally on dut_out.

Optional Feature:
- Macro: BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK ends the run at that edge.
  - busy=0, done=1, pass=0, err_count=1, fail_vec=vec.
  - dut_in keeps the failing vector for debug.
- Not defined: the run always covers all 2^N_IN vectors and err_count totals every mismatch.

Test Plan:
1. Defaults, correct 3-input AND model, start pulse:
   - dut_in steps 0..7, each held 3 cycles.
   - done=1 at start+24, pass=1, err_count=0, fail_vec=0.
2. DUT stuck-at-0, defaults:
   - done at start+24, pass=0, err_count=1, fail_vec=7.
3. DUT stuck-at-1:
   - Macro not defined: err_count=7, fail_vec=0, done at start+24.
   - Macro defined: done at start+3, err_count=1, fail_vec=0, dut_in=0.
4. OP=2 (XOR) golden with an AND DUT:
   - Mismatches at vectors 1, 2 and 4, so err_count=3, fail_vec=1, pass=0.
5. Reset and start handling:
   - rst_n low at start+10: all outputs are 0 immediately.
   - After release, start runs a full clean pass in 24 cycles.
   - start pulses at start+5 during a run: no effect on timing or results.
6. Back-to-back runs:
   - A start after a fail run clears done, pass, err_count and fail_vec on acceptance.
   - A second run with a good DUT gives pass=1.
